// File: rtl/wave_line_if.sv
// Control, load and readout bundle of the wave_line solver.
// master = controller side, slave = solver side.
interface wave_line_if #(
   parameter int W = 16,
   parameter int N = 32
);
   localparam int AW = $clog2(N);

   logic                 start;
   logic [15:0]          steps;
   logic                 busy;
   logic                 done;
   logic                 sat;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic signed [W-1:0]  wr_u;
   logic signed [W-1:0]  wr_du;
   logic [AW-1:0]        rd_addr;
   logic signed [W-1:0]  rd_u;
   logic signed [W-1:0]  rd_du;

   modport master (
      output start, steps, wr_en, wr_addr, wr_u, wr_du, rd_addr,
      input  busy, done, sat, rd_u, rd_du
   );

   modport slave (
      input  start, steps, wr_en, wr_addr, wr_u, wr_du, rd_addr,
      output busy, done, sat, rd_u, rd_du
   );
endinterface

// File: rtl/wave_line.sv
// Time-multiplexed 1-D wave-equation solver: one shared signed datapath
// sweeps N cells per timestep (Jacobi update) with saturation and damping.
module wave_line #(
   parameter int W          = 16,
   parameter int N          = 32,
   parameter int C_SHIFT    = 6,
   parameter int DT_SHIFT   = 8,
   parameter int DAMP_NUM   = 2047,
   parameter int DAMP_SHIFT = 11,
   parameter int BOUNDARY   = 0
) (
   input logic        clk,
   input logic        rst,
   wave_line_if.slave bus
);
   localparam int AW = $clog2(N);
   localparam int LW = W + 2;
   localparam int PW = W + 34;
   localparam logic signed [PW-1:0] MAX_V = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

   typedef enum logic [1:0] {IDLE, PRIME, CELL, NEXT} state_t;

   state_t              state_reg, state_next;
   logic [AW-1:0]       idx_reg;
   logic [15:0]         steps_reg;
   logic signed [W-1:0] first_old_reg, left_old_reg;
   logic                done_reg, sat_reg;
   logic signed [W-1:0] rd_u_reg, rd_du_reg;

   logic signed [W-1:0] u_arr  [N];
   logic signed [W-1:0] du_arr [N];

   logic busy, accept, prime_en, cell_en, host_we, finish;
   logic last_cell, last_step, rd_ok, wr_ok;

   assign last_cell = (idx_reg == AW'(N - 1));
   assign last_step = (steps_reg == 16'd1);

   generate
      if (2 ** AW == N) begin : g_full_range
         assign rd_ok = 1'b1;
         assign wr_ok = 1'b1;
      end else begin : g_part_range
         assign rd_ok = ({1'b0, bus.rd_addr} < (AW + 1)'(N));
         assign wr_ok = ({1'b0, bus.wr_addr} < (AW + 1)'(N));
      end
   endgenerate

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start && bus.steps != 16'd0) state_next = PRIME;
         PRIME:   state_next = CELL;
         CELL:    if (last_cell) state_next = NEXT;
         NEXT:    state_next = last_step ? IDLE : PRIME;
         default: state_next = IDLE;
      endcase
   end

   // output / control decode
   always_comb begin
      busy     = (state_reg != IDLE);
      accept   = (state_reg == IDLE) && bus.start;
      prime_en = (state_reg == PRIME);
      cell_en  = (state_reg == CELL);
      host_we  = (state_reg == IDLE) && bus.wr_en && wr_ok;
      finish   = (accept && bus.steps == 16'd0) || (state_reg == NEXT && last_step);
   end

   // shared cell datapath
   logic signed [W-1:0]  u_cur, du_cur, u_right, u_new, du_new;
   logic [AW-1:0]        idx_p1;
   logic signed [LW-1:0] lap;
   logic signed [PW-1:0] du_full, u_sum, u_prod, u_full;
   logic                 clamp_any;

   always_comb begin
      u_cur   = u_arr[idx_reg];
      du_cur  = du_arr[idx_reg];
      idx_p1  = last_cell ? '0 : idx_reg + 1'b1;
      // past the last cell the right neighbour is the wall or the saved u[0]
      if (last_cell) u_right = (BOUNDARY != 0) ? first_old_reg : '0;
      else           u_right = u_arr[idx_p1];

      lap     = LW'(left_old_reg) + LW'(u_right) - (LW'(u_cur) <<< 1);
      du_full = PW'(du_cur) + PW'(lap >>> C_SHIFT);
      u_sum   = PW'(u_cur) + PW'(du_cur >>> DT_SHIFT);
      u_prod  = u_sum * PW'(DAMP_NUM);
      u_full  = u_prod >>> DAMP_SHIFT;

      clamp_any = 1'b0;
      if (du_full > MAX_V)      begin du_new = MAX_V[W-1:0]; clamp_any = 1'b1; end
      else if (du_full < MIN_V) begin du_new = MIN_V[W-1:0]; clamp_any = 1'b1; end
      else                            du_new = du_full[W-1:0];
      if (u_full > MAX_V)       begin u_new = MAX_V[W-1:0];  clamp_any = 1'b1; end
      else if (u_full < MIN_V)  begin u_new = MIN_V[W-1:0];  clamp_any = 1'b1; end
      else                            u_new = u_full[W-1:0];
   end

   // sequencing registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg       <= '0;
         steps_reg     <= '0;
         first_old_reg <= '0;
         left_old_reg  <= '0;
         done_reg      <= 1'b0;
         sat_reg       <= 1'b0;
      end else begin
         done_reg <= finish;
         if (accept) begin
            steps_reg <= bus.steps;
            sat_reg   <= 1'b0;
         end else if (state_reg == NEXT) begin
            steps_reg <= steps_reg - 16'd1;
         end
         if (prime_en) begin
            first_old_reg <= u_arr[0];
            left_old_reg  <= (BOUNDARY != 0) ? u_arr[N-1] : '0;
            idx_reg       <= '0;
         end
         if (cell_en) begin
            left_old_reg <= u_cur;
            idx_reg      <= idx_p1;
            if (clamp_any) sat_reg <= 1'b1;
         end
      end
   end

   // cell storage: datapath write-back while running, host load while idle
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cell
         logic signed [W-1:0] u_q, du_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               u_q  <= '0;
               du_q <= '0;
            end else if (cell_en && idx_reg == AW'(gi)) begin
               u_q  <= u_new;
               du_q <= du_new;
            end else if (host_we && bus.wr_addr == AW'(gi)) begin
               u_q  <= bus.wr_u;
               du_q <= bus.wr_du;
            end
         end
         assign u_arr[gi]  = u_q;
         assign du_arr[gi] = du_q;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_u_reg  <= '0;
         rd_du_reg <= '0;
      end else if (rd_ok) begin
         rd_u_reg  <= u_arr[bus.rd_addr];
         rd_du_reg <= du_arr[bus.rd_addr];
      end else begin
         rd_u_reg  <= '0;
         rd_du_reg <= '0;
      end
   end

   assign bus.busy  = busy;
   assign bus.done  = done_reg;
   assign bus.sat   = sat_reg;
   assign bus.rd_u  = rd_u_reg;
   assign bus.rd_du = rd_du_reg;
endmodule

// File: tb/tb_wave_line.sv
// Scoreboard bench: a fixed-boundary and a periodic-boundary solver get the same
// stimulus; expected cell contents and run timing come from an array model.
module tb_wave_line;
   localparam int W = 16;
   localparam int N = 32;
   localparam int AW = $clog2(N);
   localparam int C_SHIFT = 6;
   localparam int DT_SHIFT = 8;
   localparam int DAMP_NUM = 2047;
   localparam int DAMP_SHIFT = 11;
   localparam int SMAX = 32767;
   localparam int SMIN = -32768;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                start = 1'b0;
   logic [15:0]         steps = '0;
   logic                wr_en = 1'b0;
   logic [AW-1:0]       wr_addr = '0;
   logic signed [W-1:0] wr_u = '0;
   logic signed [W-1:0] wr_du = '0;
   logic [AW-1:0]       rd_addr = '0;
   logic                rd_req = 1'b0;
   logic                rd_vld = 1'b0;

   wave_line_if #(.W(W), .N(N)) bf ();
   wave_line_if #(.W(W), .N(N)) bp ();

   assign bf.start = start;   assign bp.start = start;
   assign bf.steps = steps;   assign bp.steps = steps;
   assign bf.wr_en = wr_en;   assign bp.wr_en = wr_en;
   assign bf.wr_addr = wr_addr; assign bp.wr_addr = wr_addr;
   assign bf.wr_u = wr_u;     assign bp.wr_u = wr_u;
   assign bf.wr_du = wr_du;   assign bp.wr_du = wr_du;
   assign bf.rd_addr = rd_addr; assign bp.rd_addr = rd_addr;

   wave_line #(.W(W), .N(N), .BOUNDARY(0)) dut_fixed (.clk(clk), .rst(rst), .bus(bf));
   wave_line #(.W(W), .N(N), .BOUNDARY(1)) dut_periodic (.clk(clk), .rst(rst), .bus(bp));

   // model state: index 0 = fixed boundary, 1 = periodic
   int m_u  [2][N];
   int m_du [2][N];
   bit m_sat [2];

   typedef struct {int cyc; int sat0; int sat1;} done_exp_t;
   typedef struct {int addr; int u0; int du0; int u1; int du1;} rd_exp_t;
   done_exp_t done_q[$];
   rd_exp_t   rd_q[$];

   int n_tests = 0;
   int n_fail = 0;
   int cnt0 = 0;
   int cnt1 = 0;
   int n_done_seen = 0;

   function automatic void chk(string nm, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   function automatic int clampv(int b, longint v);
      if (v > SMAX) begin m_sat[b] = 1'b1; return SMAX; end
      if (v < SMIN) begin m_sat[b] = 1'b1; return SMIN; end
      return int'(v);
   endfunction

   function automatic void model_clear();
      for (int b = 0; b < 2; b++) begin
         m_sat[b] = 1'b0;
         for (int i = 0; i < N; i++) begin m_u[b][i] = 0; m_du[b][i] = 0; end
      end
   endfunction

   // one timestep of the whole line from a frozen copy of the old values
   function automatic void model_step(int b);
      int ou[N];
      int od[N];
      longint ul, ur, lap, un;
      for (int i = 0; i < N; i++) begin ou[i] = m_u[b][i]; od[i] = m_du[b][i]; end
      for (int i = 0; i < N; i++) begin
         ul  = (i == 0) ? ((b == 1) ? ou[N-1] : 0) : ou[i-1];
         ur  = (i == N-1) ? ((b == 1) ? ou[0] : 0) : ou[i+1];
         lap = ul + ur - 2 * longint'(ou[i]);
         m_du[b][i] = clampv(b, longint'(od[i]) + (lap >>> C_SHIFT));
         un  = ((longint'(ou[i]) + longint'(od[i] >>> DT_SHIFT)) * DAMP_NUM) >>> DAMP_SHIFT;
         m_u[b][i] = clampv(b, un);
      end
   endfunction

   always @(posedge clk) rd_vld <= rd_req;

   // monitor: run completion and read data against queued expectations
   always @(negedge clk) begin
      done_exp_t de;
      rd_exp_t   re;
      if (rst) begin
         cnt0 = 0;
         cnt1 = 0;
      end else begin
         if (bf.busy) cnt0++;
         if (bp.busy) cnt1++;
         if (bf.done || bp.done) begin
            n_done_seen++;
            if (done_q.size() == 0) begin
               chk("unexpected_done", int'(bf.done) + int'(bp.done), 0);
            end else begin
               de = done_q.pop_front();
               chk("done_fixed", int'(bf.done), 1);
               chk("done_periodic", int'(bp.done), 1);
               chk("busy_cycles_fixed", cnt0, de.cyc);
               chk("busy_cycles_periodic", cnt1, de.cyc);
               chk("busy_at_done", int'(bf.busy), 0);
               chk("sat_fixed", int'(bf.sat), de.sat0);
               chk("sat_periodic", int'(bp.sat), de.sat1);
               $display("[TB] run done: %0d busy cycles, sat %0d/%0d", cnt0, bf.sat, bp.sat);
            end
            cnt0 = 0;
            cnt1 = 0;
         end
         if (rd_vld && rd_q.size() != 0) begin
            re = rd_q.pop_front();
            chk($sformatf("rd_u_fixed[%0d]", re.addr), int'(bf.rd_u), re.u0);
            chk($sformatf("rd_du_fixed[%0d]", re.addr), int'(bf.rd_du), re.du0);
            chk($sformatf("rd_u_periodic[%0d]", re.addr), int'(bp.rd_u), re.u1);
            chk($sformatf("rd_du_periodic[%0d]", re.addr), int'(bp.rd_du), re.du1);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", int'(bf.busy) + int'(bp.busy), 0);
      chk("reset_done", int'(bf.done) + int'(bp.done), 0);
      chk("reset_sat", int'(bf.sat) + int'(bp.sat), 0);
      rst = 1'b0;
      model_clear();
      done_q.delete();
      $display("[TB] reset");
   endtask

   task automatic write_cell(int a, int u, int du);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(a); wr_u = W'(u); wr_du = W'(du);
      for (int b = 0; b < 2; b++) begin m_u[b][a] = u; m_du[b][a] = du; end
      @(negedge clk);
      wr_en = 1'b0;
      $display("[TB] write cell %0d u=%0d du=%0d", a, u, du);
   endtask

   task automatic read_all();
      rd_exp_t re;
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         rd_addr = AW'(a);
         rd_req = 1'b1;
         re.addr = a;
         re.u0 = m_u[0][a]; re.du0 = m_du[0][a];
         re.u1 = m_u[1][a]; re.du1 = m_du[1][a];
         rd_q.push_back(re);
      end
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      $display("[TB] read back %0d cells", N);
   endtask

   task automatic run(int n, bit disturb, bit with_wr, int wa, int wu, int wdu);
      done_exp_t e;
      int lim;
      bit got;
      if (with_wr) for (int b = 0; b < 2; b++) begin m_u[b][wa] = wu; m_du[b][wa] = wdu; end
      for (int b = 0; b < 2; b++) begin
         m_sat[b] = 1'b0;
         for (int s = 0; s < n; s++) model_step(b);
      end
      e.cyc = n * (N + 2); e.sat0 = int'(m_sat[0]); e.sat1 = int'(m_sat[1]);
      done_q.push_back(e);
      @(negedge clk);
      start = 1'b1;
      steps = 16'(n);
      if (with_wr) begin wr_en = 1'b1; wr_addr = AW'(wa); wr_u = W'(wu); wr_du = W'(wdu); end
      lim = n * (N + 2) + 10;
      got = 1'b0;
      for (int k = 0; k < lim && !got; k++) begin
         @(negedge clk);
         if (k == 0) begin start = 1'b0; wr_en = 1'b0; end
         if (disturb && k == 10) begin
            start = 1'b1; steps = 16'd5;
            wr_en = 1'b1; wr_addr = AW'(4); wr_u = 16'sd777; wr_du = -16'sd5;
         end
         if (disturb && k == 11) begin start = 1'b0; wr_en = 1'b0; end
         if (bf.done) got = 1'b1;
      end
      chk("done_within_budget", int'(got), 1);
      if (!got) done_q.delete();
      $display("[TB] run steps=%0d disturb=%0d with_wr=%0d", n, disturb, with_wr);
   endtask

   task automatic abort_run();
      int seen;
      @(negedge clk);
      start = 1'b1;
      steps = 16'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      seen = n_done_seen;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(bf.busy) + int'(bp.busy), 0);
      rst = 1'b0;
      model_clear();
      repeat (120) @(negedge clk);
      chk("abort_no_done", n_done_seen - seen, 0);
      $display("[TB] abort mid-run");
   endtask

   initial begin
      int nw;
      do_reset();
      read_all();

      write_cell(4, 1024, 0);
      run(1, 1'b0, 1'b0, 0, 0, 0);
      read_all();

      do_reset();
      write_cell(0, 1024, 0);
      run(1, 1'b0, 1'b0, 0, 0, 0);
      read_all();

      do_reset();
      write_cell(7, 0, -1);
      run(1, 1'b0, 1'b0, 0, 0, 0);
      read_all();

      do_reset();
      write_cell(2, 32767, 32767);
      run(1, 1'b0, 1'b0, 0, 0, 0);
      read_all();
      run(0, 1'b0, 1'b0, 0, 0, 0);

      for (int r = 0; r < 4; r++) begin
         nw = int'($urandom_range(1, 6));
         for (int j = 0; j < nw; j++)
            write_cell(int'($urandom_range(0, N - 1)),
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 4095)) - 2048);
         run(int'($urandom_range(1, 3)), 1'b0, r[0], int'($urandom_range(0, N - 1)),
             int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 511)) - 256);
         read_all();
      end

      run(3, 1'b1, 1'b0, 0, 0, 0);
      read_all();

      abort_run();
      read_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end
endmodule
